result_tx_framer: RTL and testbench

RESULT_TX_FRAMER -- requirements
Module: result_tx_framer

---
 rtl/result_tx_framer_pkg.sv | 66 ++++++
 rtl/result_fifo.sv | 63 ++++++
 rtl/result_tx_framer.sv | 165 ++++++++++++++++
 tb/tb_result_tx_framer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/result_tx_framer_pkg.sv
// Shared definitions for the result UART framer.
// Contents: FSM state encoding, frame lengths (raw = 2 bytes, ASCII hex = 6 bytes),
// CR/LF constants and the byte-selection helpers used to build a frame from a 16-bit word.
package result_tx_framer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    localparam int unsigned RAW_FRAME_LEN = 32'd2;
    localparam int unsigned HEX_FRAME_LEN = 32'd6;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Uppercase ASCII character for one hex digit ('A' is 0x37 + 10).
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        logic [7:0] chr;
        if (nib < 4'd10) begin
            chr = 8'h30 + {4'h0, nib};
        end else begin
            chr = 8'h37 + {4'h0, nib};
        end
        return chr;
    endfunction

    // Raw frame: byte 0 is the high byte when msb_first, otherwise the low byte.
    function automatic logic [7:0] raw_byte(input logic [15:0] word,
                                            input logic [2:0]  idx,
                                            input logic        msb_first);
        logic hi;
        if (idx == 3'd0) begin
            hi = msb_first;
        end else begin
            hi = ~msb_first;
        end
        return hi ? word[15:8] : word[7:0];
    endfunction

    // ASCII frame: four hex digits, then CR, then LF.
    function automatic logic [7:0] hex_byte(input logic [15:0] word,
                                            input logic [2:0]  idx,
                                            input logic        msb_first);
        logic [1:0] pos;
        logic [3:0] nib;
        logic [7:0] chr;
        pos = msb_first ? (2'd3 - idx[1:0]) : idx[1:0];
        case (pos)
            2'd3:    nib = word[15:12];
            2'd2:    nib = word[11:8];
            2'd1:    nib = word[7:4];
            default: nib = word[3:0];
        endcase
        case (idx)
            3'd0, 3'd1, 3'd2, 3'd3: chr = hex_ascii(nib);
            3'd4:                   chr = ASCII_CR;
            3'd5:                   chr = ASCII_LF;
            default:                chr = 8'h00;
        endcase
        return chr;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous single-clock word FIFO with show-ahead read data.
// Ports: clk/rst_n (async active-low), wr_en/wr_data (write accepted when not full,
// or when full together with a read), rd_en (pop, ignored when empty), rd_data
// (word at the head), full, empty, count (words held).
// DEPTH must be a power of two so the pointers wrap naturally.
module result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             wr_acc_s;
    logic             rd_acc_s;

    assign full     = (count_r == (AW+1)'(DEPTH));
    assign empty    = (count_r == {(AW+1){1'b0}});
    assign count    = count_r;
    assign rd_data  = mem_r[rd_ptr_r];
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign wr_acc_s = wr_en && (!full || rd_en);
    assign rd_acc_s = rd_en && !empty;

    // Storage array and pointers; the count moves only when exactly one side is active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (wr_acc_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({wr_acc_s, rd_acc_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/result_tx_framer.sv
// Buffers 16-bit multiplier results and feeds them byte by byte to a UART transmitter.
// Ports: clk_fpga (only clock), reset (async active-low), i_result/i_result_valid
// (result strobe), o_tx_dv/o_tx_byte (byte start to UART), i_tx_active/i_tx_done
// (UART status), o_busy, o_overflow (sticky drop flag), o_fifo_count.
// Build option: define ASCII_HEX_EN for a 6-byte ASCII hex + CR/LF frame per word;
// otherwise each word goes out as 2 raw bytes. MSB_FIRST picks the byte/digit order.
module result_tx_framer
    import result_tx_framer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                          clk_fpga,
    input  logic                          reset,
    input  logic [15:0]                   i_result,
    input  logic                          i_result_valid,
    output logic                          o_tx_dv,
    output logic [7:0]                    o_tx_byte,
    input  logic                          i_tx_active,
    input  logic                          i_tx_done,
    output logic                          o_busy,
    output logic                          o_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef ASCII_HEX_EN
    localparam int unsigned FRAME_LEN = HEX_FRAME_LEN;
`else
    localparam int unsigned FRAME_LEN = RAW_FRAME_LEN;
`endif
    localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

    state_t          state_r;
    state_t          state_next_s;
    logic [2:0]      idx_r;
    logic [2:0]      idx_next_s;
    logic [15:0]     frame_r;
    logic            pop_s;
    logic            wr_acc_s;
    logic            drop_s;
    logic            dv_next_s;
    logic [7:0]      frame_byte_s;
    logic [7:0]      byte_next_s;
    logic            busy_next_s;
    logic [CW-1:0]   count_next_s;
    logic            tx_dv_r;
    logic [7:0]      tx_byte_r;
    logic            busy_r;
    logic            overflow_r;
    logic [15:0]     fifo_rd_data_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic [CW-1:0]   fifo_count_s;

    result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk     (clk_fpga),
        .rst_n   (reset),
        .wr_en   (i_result_valid),
        .wr_data (i_result),
        .rd_en   (pop_s),
        .rd_data (fifo_rd_data_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    assign wr_acc_s = i_result_valid && (!fifo_full_s || pop_s);
    assign drop_s   = i_result_valid && fifo_full_s && !pop_s;

    // Next-state and byte index; the index only advances below the last byte, so it saturates.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        pop_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s && !i_tx_active) begin
                    pop_s        = 1'b1;
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                idx_next_s   = 3'd0;
                state_next_s = ST_SEND;
            end
            ST_SEND: begin
                state_next_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_tx_done) begin
                    if (idx_r == LAST_IDX) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        idx_next_s   = idx_r + 3'd1;
                        state_next_s = ST_SEND;
                    end
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output look-ahead: the strobe and byte are registered on entry to SEND so they
    // appear in the SEND cycle itself; the byte then holds until the next SEND.
    always_comb begin
`ifdef ASCII_HEX_EN
        frame_byte_s = hex_byte(frame_r, idx_next_s, MSB_FIRST);
`else
        frame_byte_s = raw_byte(frame_r, idx_next_s, MSB_FIRST);
`endif
        dv_next_s = (state_next_s == ST_SEND);
        if (dv_next_s) begin
            byte_next_s = frame_byte_s;
        end else begin
            byte_next_s = tx_byte_r;
        end
        case ({wr_acc_s, pop_s})
            2'b10:   count_next_s = fifo_count_s + CW'(1);
            2'b01:   count_next_s = fifo_count_s - CW'(1);
            default: count_next_s = fifo_count_s;
        endcase
        busy_next_s = (state_next_s != ST_IDLE) || (count_next_s != {CW{1'b0}});
    end

    // State, frame capture and registered outputs. The head word is captured on the pop
    // edge because the FIFO head advances at that same edge.
    always_ff @(posedge clk_fpga or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            idx_r      <= 3'd0;
            frame_r    <= 16'h0000;
            tx_dv_r    <= 1'b0;
            tx_byte_r  <= 8'h00;
            busy_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            idx_r      <= idx_next_s;
            if (pop_s) begin
                frame_r <= fifo_rd_data_s;
            end
            tx_dv_r    <= dv_next_s;
            tx_byte_r  <= byte_next_s;
            busy_r     <= busy_next_s;
            overflow_r <= overflow_r | drop_s;
        end
    end

    assign o_tx_dv      = tx_dv_r;
    assign o_tx_byte    = tx_byte_r;
    assign o_busy       = busy_r;
    assign o_overflow   = overflow_r;
    assign o_fifo_count = fifo_count_s;

endmodule

// File: tb/tb_result_tx_framer.sv
// Directed self-checking bench for result_tx_framer (default FIFO_DEPTH=4, MSB_FIRST=1).
// Follows ASCII_HEX_EN for the expected frame contents.
module tb_result_tx_framer;

`ifdef ASCII_HEX_EN
    localparam int FLEN = 6;
`else
    localparam int FLEN = 2;
`endif

    logic        clk_fpga = 1'b0;
    logic        reset    = 1'b0;
    logic [15:0] i_result = 16'h0000;
    logic        i_result_valid = 1'b0;
    logic        i_tx_active = 1'b0;
    logic        i_tx_done = 1'b0;
    logic        o_tx_dv;
    logic [7:0]  o_tx_byte;
    logic        o_busy;
    logic        o_overflow;
    logic [2:0]  o_fifo_count;

    int total = 0;
    int bad   = 0;
    logic [7:0] tab [FLEN];

    result_tx_framer dut (
        .clk_fpga       (clk_fpga),
        .reset          (reset),
        .i_result       (i_result),
        .i_result_valid (i_result_valid),
        .o_tx_dv        (o_tx_dv),
        .o_tx_byte      (o_tx_byte),
        .i_tx_active    (i_tx_active),
        .i_tx_done      (i_tx_done),
        .o_busy         (o_busy),
        .o_overflow     (o_overflow),
        .o_fifo_count   (o_fifo_count)
    );

    always #5 clk_fpga = ~clk_fpga;

    task automatic tick();
        @(posedge clk_fpga);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Independent model of frame byte i for word w (MSB first).
    function automatic logic [7:0] exp_byte(input logic [15:0] w, input int i);
`ifdef ASCII_HEX_EN
        string hx;
        logic [3:0] nib;
        hx = "0123456789ABCDEF";
        if (i == 4) return 8'h0D;
        if (i == 5) return 8'h0A;
        nib = 4'(w >> (4 * (3 - i)));
        return hx[nib];
`else
        return (i == 0) ? w[15:8] : w[7:0];
`endif
    endfunction

    // Wait (bounded) for each byte strobe of one frame, check it, then acknowledge it.
    task automatic send_frame(input logic [15:0] w);
        int n;
        for (int i = 0; i < FLEN; i++) begin
            n = 0;
            while (o_tx_dv !== 1'b1 && n < 8) begin
                tick();
                n++;
            end
            chk("frame_dv", {31'd0, o_tx_dv}, 32'd1);
            chk("frame_byte", {24'd0, o_tx_byte}, {24'd0, exp_byte(w, i)});
            tick();
            chk("frame_dv_one_cycle", {31'd0, o_tx_dv}, 32'd0);
            i_tx_done = 1'b1;
            tick();
            i_tx_done = 1'b0;
        end
    endtask

    initial begin
        int dv_cnt;
`ifdef ASCII_HEX_EN
        tab[0] = 8'h41; tab[1] = 8'h35; tab[2] = 8'h43;
        tab[3] = 8'h33; tab[4] = 8'h0D; tab[5] = 8'h0A;
`else
        tab[0] = 8'hA5; tab[1] = 8'hC3;
`endif
        // Reset state
        #12;
        chk("rst_dv", {31'd0, o_tx_dv}, 32'd0);
        chk("rst_byte", {24'd0, o_tx_byte}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_ovf", {31'd0, o_overflow}, 32'd0);
        chk("rst_count", {29'd0, o_fifo_count}, 32'd0);
        reset = 1'b1;
        tick();

        // 0xA5C3 frame with latency N+3
        i_result = 16'hA5C3;
        i_result_valid = 1'b1;
        tick();
        i_result_valid = 1'b0;
        chk("lat_n1_dv", {31'd0, o_tx_dv}, 32'd0);
        chk("lat_n1_count", {29'd0, o_fifo_count}, 32'd1);
        chk("lat_n1_busy", {31'd0, o_busy}, 32'd1);
        tick();
        chk("lat_n2_dv", {31'd0, o_tx_dv}, 32'd0);
        chk("lat_n2_count", {29'd0, o_fifo_count}, 32'd0);
        tick();
        for (int i = 0; i < FLEN; i++) begin
            chk("a5c3_dv", {31'd0, o_tx_dv}, 32'd1);
            chk("a5c3_byte", {24'd0, o_tx_byte}, {24'd0, tab[i]});
            tick();
            chk("a5c3_dv_low", {31'd0, o_tx_dv}, 32'd0);
            chk("a5c3_byte_hold", {24'd0, o_tx_byte}, {24'd0, tab[i]});
            chk("a5c3_busy", {31'd0, o_busy}, 32'd1);
            i_tx_done = 1'b1;
            tick();
            i_tx_done = 1'b0;
        end
        chk("a5c3_busy_end", {31'd0, o_busy}, 32'd0);
        chk("a5c3_dv_end", {31'd0, o_tx_dv}, 32'd0);

        // Stray done in idle
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        dv_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            if (o_tx_dv === 1'b1) dv_cnt++;
            tick();
        end
        chk("stray_dv", dv_cnt, 32'd0);
        chk("stray_busy", {31'd0, o_busy}, 32'd0);

        // Overflow: six writes with the transmitter busy
        i_tx_active = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            i_result = 16'(k);
            i_result_valid = 1'b1;
            tick();
            if (k == 4) chk("ovf_before_drop", {31'd0, o_overflow}, 32'd0);
        end
        i_result_valid = 1'b0;
        chk("ovf_count", {29'd0, o_fifo_count}, 32'd4);
        chk("ovf_flag", {31'd0, o_overflow}, 32'd1);
        chk("ovf_no_dv", {31'd0, o_tx_dv}, 32'd0);
        i_tx_active = 1'b0;
        for (int k = 1; k <= 4; k++) send_frame(16'(k));
        chk("ovf_drained", {29'd0, o_fifo_count}, 32'd0);
        chk("ovf_sticky", {31'd0, o_overflow}, 32'd1);
        tick();
        chk("ovf_no_extra_dv", {31'd0, o_tx_dv}, 32'd0);

        // Reset during WAIT of the second byte
        i_result = 16'hBEEF;
        i_result_valid = 1'b1;
        tick();
        i_result_valid = 1'b0;
        tick();
        tick();
        chk("mid_dv0", {31'd0, o_tx_dv}, 32'd1);
        tick();
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        chk("mid_dv1", {31'd0, o_tx_dv}, 32'd1);
        tick();
        reset = 1'b0;
        #2;
        chk("mid_rst_dv", {31'd0, o_tx_dv}, 32'd0);
        chk("mid_rst_byte", {24'd0, o_tx_byte}, 32'd0);
        chk("mid_rst_busy", {31'd0, o_busy}, 32'd0);
        chk("mid_rst_ovf", {31'd0, o_overflow}, 32'd0);
        chk("mid_rst_count", {29'd0, o_fifo_count}, 32'd0);
        reset = 1'b1;
        dv_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            i_tx_done = (k == 3) ? 1'b1 : 1'b0;
            tick();
            if (o_tx_dv === 1'b1) dv_cnt++;
        end
        i_tx_done = 1'b0;
        chk("mid_no_residual", dv_cnt, 32'd0);
        chk("mid_busy_after", {31'd0, o_busy}, 32'd0);

        // Full FIFO with a pop and a write in the same cycle
        i_tx_active = 1'b1;
        for (int k = 0; k < 4; k++) begin
            i_result = 16'h0011 + 16'(k);
            i_result_valid = 1'b1;
            tick();
        end
        chk("full_count", {29'd0, o_fifo_count}, 32'd4);
        i_tx_active = 1'b0;
        i_result = 16'h0015;
        tick();
        i_result_valid = 1'b0;
        chk("simul_count", {29'd0, o_fifo_count}, 32'd4);
        chk("simul_ovf", {31'd0, o_overflow}, 32'd0);
        for (int k = 0; k < 5; k++) send_frame(16'h0011 + 16'(k));
        chk("simul_drained", {29'd0, o_fifo_count}, 32'd0);
        chk("simul_busy_end", {31'd0, o_busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
